puf_resp_readout: RTL and testbench
===================================

PUF_RESP_READOUT -- requirements
Module: puf_resp_readout

Interface
REQ-001 Parameters: none; response width fixed at 128 bits, byte width 8, 16 bytes per response.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 DONE_IN  input  1  completion strobe from the XOR-PUF stimulus controller.
REQ-005 PUF_IN  input  128  registered PUF response from the stimulus controller; valid while DONE_IN high.
REQ-006 RD_REQ  input  1  byte read request from the SPI slave; one request per high cycle.
REQ-007 RD_RESTART  input  1  rewind the read pointer to byte 0.
REQ-008 RD_DATA  output  8  returned response byte.
REQ-009 RD_VALID  output  1  RD_DATA valid; one-cycle pulse per accepted request.
REQ-010 RESP_READY  output  1  a captured response is counted and not yet fully read.
REQ-011 HW_COUNT  output  8  Hamming weight of the last counted response, 0..128.
REQ-012 OVERRUN  output  1  sticky flag; a completion arrived while a response was still pending.

Function
REQ-013 The block SHALL detect a DONE_IN rising edge as DONE_IN=1 with the previous-cycle register DONE_Q=0; a level held high SHALL produce exactly one event.
REQ-014 The state machine SHALL have three states: IDLE, COUNT, READY.
REQ-015 IDLE: on a rising edge at clock edge T, the block SHALL capture PUF_IN into a 128-bit buffer, clear the accumulator and byte index, and enter COUNT.
REQ-016 COUNT: each cycle the block SHALL add the popcount of buffer byte[idx] (bits 8*idx+7:8*idx) to a 8-bit accumulator and increment idx; exactly 16 COUNT cycles SHALL occur.
REQ-017 At edge T+16 the block SHALL load HW_COUNT with the final sum, set RESP_READY=1, clear the read pointer and enter READY; HW_COUNT SHALL not change during COUNT.
REQ-018 READY: RD_REQ=1 at edge E SHALL drive RD_DATA=buffer byte[ptr] and RD_VALID=1 for the cycle after E, then increment ptr; byte 0 = PUF_IN[7:0] (LSB first).
REQ-019 When the 16th byte (ptr=15) is read, the block SHALL clear RESP_READY and return to IDLE at the same edge; ptr SHALL not wrap.
REQ-020 RD_RESTART=1 in READY SHALL set ptr=0; RD_RESTART and RD_REQ together SHALL return byte 0 and leave ptr=1.
REQ-021 RD_REQ and RD_RESTART outside READY SHALL be ignored; RD_VALID stays 0 and RD_DATA holds its value.
REQ-022 A DONE_IN rising edge in COUNT or READY SHALL set OVERRUN=1 and be discarded; the buffer, counts and pointer are unaffected.
REQ-023 OVERRUN SHALL stay set until RESET.
REQ-024 HW_COUNT SHALL hold its value from completion until the next COUNT completes.
REQ-025 RD_VALID SHALL never be high for two consecutive cycles unless RD_REQ was high on both preceding edges.

Reset
REQ-026 RESET=1 at an edge SHALL force IDLE and clear the buffer, accumulator, idx, ptr, RD_DATA, RD_VALID, RESP_READY, HW_COUNT and OVERRUN to 0.
REQ-027 RESET SHALL set DONE_Q=1, so DONE_IN held high through reset release does not trigger a capture.
REQ-028 RESET in COUNT or READY SHALL abandon the response; no RD_VALID pulse SHALL follow.

Verification
REQ-029 Capture 128'h00112233445566778899AABBCCDDEEFF -> RESP_READY rises 16 cycles after capture, HW_COUNT=64; 16 RD_REQ return FF,EE,DD,...,11,00; RESP_READY falls with the last byte.
REQ-030 All-ones and all-zeros responses -> HW_COUNT=128 (8'h80) with all bytes FF, and HW_COUNT=0 with all bytes 00.
REQ-031 Second DONE_IN pulse during COUNT and again in READY -> OVERRUN=1, read data still matches the first response, and OVERRUN stays 1 after a later normal capture.
REQ-032 Read 5 bytes, assert RD_RESTART together with RD_REQ -> byte 0 returned; the next read returns byte 1; a full sequence then completes normally.
REQ-033 DONE_IN held high 10 cycles -> one capture; DONE_IN high across RESET release -> no capture.
REQ-034 RESET asserted at the 8th COUNT cycle -> all outputs 0, IDLE; a subsequent capture counts correctly.

Source files
------------

// File: rtl/puf_resp_readout.sv
// PUF response readout: captures a 128-bit XOR-PUF response, counts its Hamming
// weight one byte per cycle, then serves it LSB byte first to the SPI slave.
//
// state    | meaning
// ST_IDLE  | waiting for a DONE_IN rising edge to capture a response
// ST_COUNT | 16 cycles accumulating the popcount of one buffer byte each
// ST_READY | response counted; serving byte reads until all 16 are taken
module puf_resp_readout (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         DONE_IN,
   input  logic [127:0] PUF_IN,
   input  logic         RD_REQ,
   input  logic         RD_RESTART,
   output logic [7:0]   RD_DATA,
   output logic         RD_VALID,
   output logic         RESP_READY,
   output logic [7:0]   HW_COUNT,
   output logic         OVERRUN
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   logic [1:0]   state_q, state_d;
   logic         done_q, done_d;
   logic [127:0] buf_q, buf_d;
   logic [7:0]   acc_q, acc_d;
   logic [3:0]   idx_q, idx_d;
   logic [3:0]   ptr_q, ptr_d;
   logic [7:0]   rd_data_q, rd_data_d;
   logic         rd_valid_q, rd_valid_d;
   logic         resp_ready_q, resp_ready_d;
   logic [7:0]   hw_count_q, hw_count_d;
   logic         overrun_q, overrun_d;

   logic         done_rise;
   logic [7:0]   cnt_byte;
   logic [7:0]   rd_byte;

   function automatic logic [3:0] popcnt8(input logic [7:0] b);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, b[i]};
      end
      return n;
   endfunction

   always_comb begin
      state_d      = state_q;
      done_d       = DONE_IN;
      buf_d        = buf_q;
      acc_d        = acc_q;
      idx_d        = idx_q;
      ptr_d        = ptr_q;
      rd_data_d    = rd_data_q;
      rd_valid_d   = 1'b0;
      resp_ready_d = resp_ready_q;
      hw_count_d   = hw_count_q;
      overrun_d    = overrun_q;

      done_rise = DONE_IN & ~done_q;
      cnt_byte  = buf_q[{idx_q, 3'b000} +: 8];
      rd_byte   = buf_q[{ptr_q, 3'b000} +: 8];

      case (state_q)
         ST_IDLE: begin
            if (done_rise) begin
               buf_d   = PUF_IN;
               acc_d   = 8'd0;
               idx_d   = 4'd0;
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (done_rise) overrun_d = 1'b1;
            acc_d = acc_q + {4'd0, popcnt8(cnt_byte)};
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
               hw_count_d   = acc_d;
               resp_ready_d = 1'b1;
               ptr_d        = 4'd0;
               state_d      = ST_READY;
            end
         end
         ST_READY: begin
            if (done_rise) overrun_d = 1'b1;
            if (RD_REQ) begin
               rd_valid_d = 1'b1;
               // Restart with a read returns byte 0 and continues from byte 1.
               if (RD_RESTART) begin
                  rd_data_d = buf_q[7:0];
                  ptr_d     = 4'd1;
               end else begin
                  rd_data_d = rd_byte;
                  if (ptr_q == 4'd15) begin
                     resp_ready_d = 1'b0;
                     state_d      = ST_IDLE;
                  end else begin
                     ptr_d = ptr_q + 4'd1;
                  end
               end
            end else if (RD_RESTART) begin
               ptr_d = 4'd0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // done_q resets high so a DONE_IN level held through reset is not an edge.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         done_q       <= 1'b1;
         buf_q        <= '0;
         acc_q        <= '0;
         idx_q        <= '0;
         ptr_q        <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         resp_ready_q <= 1'b0;
         hw_count_q   <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         done_q       <= done_d;
         buf_q        <= buf_d;
         acc_q        <= acc_d;
         idx_q        <= idx_d;
         ptr_q        <= ptr_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         resp_ready_q <= resp_ready_d;
         hw_count_q   <= hw_count_d;
         overrun_q    <= overrun_d;
      end
   end

   assign RD_DATA    = rd_data_q;
   assign RD_VALID   = rd_valid_q;
   assign RESP_READY = resp_ready_q;
   assign HW_COUNT   = hw_count_q;
   assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_puf_resp_readout.sv
// Bench for puf_resp_readout: directed captures with hand-computed weights; read
// bytes are pushed to a scoreboard queue and checked by an independent monitor.
module tb_puf_resp_readout;

   logic         CLK = 1'b0;
   logic         RESET = 1'b1;
   logic         DONE_IN = 1'b0;
   logic [127:0] PUF_IN = '0;
   logic         RD_REQ = 1'b0;
   logic         RD_RESTART = 1'b0;
   logic [7:0]   RD_DATA;
   logic         RD_VALID;
   logic         RESP_READY;
   logic [7:0]   HW_COUNT;
   logic         OVERRUN;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] sb[$];
   logic [7:0] prev_hw = 8'd0;

   localparam logic [127:0] V_A = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] V_C = 128'hDEADBEEF00000000000000000000000F;
   localparam logic [127:0] V_Y = 128'h8000000000000000000000000000F0F0;

   puf_resp_readout dut (
      .CLK(CLK), .RESET(RESET), .DONE_IN(DONE_IN), .PUF_IN(PUF_IN),
      .RD_REQ(RD_REQ), .RD_RESTART(RD_RESTART), .RD_DATA(RD_DATA),
      .RD_VALID(RD_VALID), .RESP_READY(RESP_READY), .HW_COUNT(HW_COUNT),
      .OVERRUN(OVERRUN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (RD_VALID === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_rd_valid", 32'(RD_VALID), 32'd0);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            check("rd_data", 32'(RD_DATA), 32'(e));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Capture v; optional extra DONE pulse in COUNT, held level, or reset at COUNT cycle rst_at.
   task automatic capture(input logic [127:0] v, input logic [7:0] hw,
                          input bit inj, input int hold, input int rst_at);
      DONE_IN = 1'b1;
      PUF_IN  = v;
      tick(1);
      for (int k = 1; k <= 16; k++) begin
         DONE_IN = (k < hold);
         if (inj && k == 5) begin
            DONE_IN = 1'b1;
            PUF_IN  = ~v;
         end
         if (rst_at == k) RESET = 1'b1;
         tick(1);
         if (rst_at == k) begin
            RESET   = 1'b0;
            DONE_IN = 1'b0;
            check("rst_rd_data", 32'(RD_DATA), 32'd0);
            check("rst_rd_valid", 32'(RD_VALID), 32'd0);
            check("rst_resp_ready", 32'(RESP_READY), 32'd0);
            check("rst_hw_count", 32'(HW_COUNT), 32'd0);
            check("rst_overrun", 32'(OVERRUN), 32'd0);
            prev_hw = 8'd0;
            tick(1);
            return;
         end
         if (k == 8)  check("hw_hold_in_count", 32'(HW_COUNT), 32'(prev_hw));
         if (k == 15) check("resp_ready_early", 32'(RESP_READY), 32'd0);
         if (k == 16) begin
            check("resp_ready_rise", 32'(RESP_READY), 32'd1);
            check("hw_count", 32'(HW_COUNT), 32'(hw));
         end
      end
      DONE_IN = 1'b0;
      prev_hw = hw;
   endtask

   task automatic read_resp(input logic [127:0] v, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         RD_REQ = 1'b1;
         sb.push_back(v[8*i +: 8]);
         tick(1);
         RD_REQ = 1'b0;
         check("resp_ready_during_read", 32'(RESP_READY), (i == 15) ? 32'd0 : 32'd1);
         tick(1);
      end
   endtask

   task automatic idle_reads(input logic [7:0] held);
      RD_REQ = 1'b1; RD_RESTART = 1'b1;
      tick(2);
      RD_REQ = 1'b0; RD_RESTART = 1'b0;
      tick(1);
      check("idle_rd_data_hold", 32'(RD_DATA), 32'(held));
   endtask

   initial begin
      tick(2);
      RESET = 1'b0;
      tick(1);
      check("reset_rd_data", 32'(RD_DATA), 32'd0);
      check("reset_resp_ready", 32'(RESP_READY), 32'd0);
      check("reset_hw_count", 32'(HW_COUNT), 32'd0);
      check("reset_overrun", 32'(OVERRUN), 32'd0);
      idle_reads(8'h00);

      capture(V_A, 8'd64, 1'b0, 0, 0);
      read_resp(V_A, 0, 15);

      capture({128{1'b1}}, 8'h80, 1'b0, 0, 0);
      read_resp({128{1'b1}}, 0, 15);
      idle_reads(8'hFF);

      capture('0, 8'h00, 1'b0, 0, 0);
      read_resp('0, 0, 15);

      // Restart with and without a simultaneous read.
      capture(V_A, 8'd64, 1'b0, 0, 0);
      read_resp(V_A, 0, 4);
      RD_REQ = 1'b1; RD_RESTART = 1'b1;
      sb.push_back(8'hFF);
      tick(1);
      RD_REQ = 1'b0; RD_RESTART = 1'b0;
      tick(1);
      read_resp(V_A, 1, 1);
      RD_RESTART = 1'b1;
      tick(1);
      RD_RESTART = 1'b0;
      tick(1);
      read_resp(V_A, 0, 15);

      // Overrun in COUNT and in READY.
      check("overrun_before", 32'(OVERRUN), 32'd0);
      capture(V_C, 8'h1C, 1'b1, 0, 0);
      check("overrun_count", 32'(OVERRUN), 32'd1);
      PUF_IN  = ~V_C;
      DONE_IN = 1'b1;
      tick(1);
      DONE_IN = 1'b0;
      tick(1);
      check("overrun_ready", 32'(OVERRUN), 32'd1);
      check("hw_after_overrun", 32'(HW_COUNT), 32'h1C);
      read_resp(V_C, 0, 15);
      capture(128'h1, 8'd1, 1'b0, 0, 0);
      check("overrun_sticky", 32'(OVERRUN), 32'd1);
      read_resp(128'h1, 0, 15);

      // DONE_IN high across reset release must not capture.
      DONE_IN = 1'b1;
      RESET   = 1'b1;
      tick(2);
      RESET = 1'b0;
      prev_hw = 8'd0;
      tick(20);
      check("no_capture_after_reset", 32'(RESP_READY), 32'd0);
      check("overrun_cleared", 32'(OVERRUN), 32'd0);
      DONE_IN = 1'b0;
      tick(1);

      capture(V_Y, 8'd9, 1'b0, 10, 0);
      check("held_done_no_overrun", 32'(OVERRUN), 32'd0);
      read_resp(V_Y, 0, 15);

      capture({128{1'b1}}, 8'h80, 1'b0, 0, 8);
      tick(4);
      check("abandoned_no_ready", 32'(RESP_READY), 32'd0);
      capture(128'h3, 8'd2, 1'b0, 0, 0);
      read_resp(128'h3, 0, 15);

      tick(3);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
